uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, clk cycles per bit; even, >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-005 SHALL have port rdata  output  8  received byte at the head of the buffer.
REQ-006 SHALL have port rdata_valid  output  1  high while at least one byte is buffered.
REQ-007 SHALL have port rdata_ready  input  1  consumer accept; a pop occurs on any cycle with rdata_valid && rdata_ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the buffer is full.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK with a tick counter of width clog2(OVERSAMPLE) and a 3-bit bit index.
REQ-012 IDLE: on rxs==0, clear the counter and go to START.
REQ-013 START: after OVERSAMPLE/2 cycles, sample rxs; 0 -> go to DATA and clear the counter; 1 -> go to IDLE (false start), with no output and no error.
REQ-014 DATA: every OVERSAMPLE cycles, sample rxs into shift[bit index], LSB first; after bit 7, go to STOP.
REQ-015 STOP: after OVERSAMPLE cycles, sample rxs; 1 -> push the byte and go to IDLE; 0 -> pulse frame_err, discard the byte, and go to BREAK.
REQ-016 BREAK: hold until rxs==1, then go to IDLE; no new start is detected while in BREAK.
REQ-017 Push latency: the byte is visible on rdata, with rdata_valid high, on the cycle after the stop-bit sample.
REQ-018 rdata SHALL stay stable while rdata_valid is high and no pop occurs.
REQ-019 Push when the buffer is full and no pop occurs in that cycle: drop the new byte, pulse overrun, and leave buffered contents unchanged.
REQ-020 Simultaneous push and pop when full: accept both; occupancy is unchanged and no overrun occurs.
REQ-021 Pop when empty: no effect.
REQ-022 frame_err and overrun are never asserted in the same cycle; a dropped byte with a bad stop bit reports frame_err only.

Reset
REQ-023 On rst, all of the following SHALL occur regardless of current state:
- state <- IDLE; counter and bit index <- 0.
- synchronizer flops <- 1.
- rdata <- 0; rdata_valid, frame_err, overrun <- 0.
- buffer emptied.
REQ-024 Reset mid-frame SHALL abandon the frame with no push and no error pulse; if rx is still low after reset, that is treated as a new start bit.

Configuration
REQ-025 Macro UART_RX_FIFO_EN defined: the buffer SHALL be a 4-entry FIFO with 2-bit wrapping pointers, a 3-bit count, and rdata showing the oldest entry.
REQ-026 Macro UART_RX_FIFO_EN undefined: the buffer SHALL be a single holding register, with full == rdata_valid.
REQ-027 Handshake, overrun, and latency rules SHALL be identical in both builds.

Verification
REQ-028 OVERSAMPLE=16, frame 0x55 with a good stop bit, rdata_ready=0 -> rdata=0x55 and rdata_valid=1 on the cycle after the stop sample; no error pulses.
REQ-029 rx low for 3 cycles, then high -> no rdata_valid, no frame_err; the state is IDLE again 8 cycles after the synchronized fall.
REQ-030 Frame 0xA3 with stop bit 0, rx held low for 40 more cycles -> exactly one frame_err pulse, rdata_valid stays 0, and no restart until rx returns high.
REQ-031 FIFO build: bytes 0x01..0x05 sent back-to-back with rdata_ready=0 -> overrun pulses once (on byte 0x05), then pops yield 0x01..0x04 in order. Non-FIFO build: bytes 0x01, 0x02 sent -> overrun on 0x02, and a pop yields 0x01.
REQ-032 rst asserted for 1 cycle during bit 4 of frame 0x7E, then a clean frame 0x3C sent -> only 0x3C is delivered, with no error pulses.
REQ-033 Buffer full, with rdata_ready=1 on the push cycle -> no overrun, and the new byte is delivered after the existing ones.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with OVERSAMPLE clocks per bit; received bytes appear on rdata the cycle after the stop-bit sample.
// rdata_valid/rdata_ready handshake; a full buffer drops new bytes and pulses overrun. Define UART_RX_FIFO_EN to get a 4-entry FIFO instead of one holding register.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  input  logic       rdata_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rxs;

  logic stop_tick;
  logic push;
  logic pop;
  logic full;
  logic accept;

  assign stop_tick = (state == STOP) && (cnt == LAST);
  assign push      = stop_tick && rxs;
  assign pop       = rdata_valid && rdata_ready;
  // A pop in the same cycle frees the slot, so a full buffer can still take the byte.
  assign accept    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      frame_err <= stop_tick && !rxs;
      overrun   <= push && full && !pop;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == MID) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= rxs ? IDLE : BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  assign full        = (count == 3'd4);
  assign rdata_valid = (count != 3'd0);
  assign rdata       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {2'b00, accept} - {2'b00, pop};
    end
  end
`else
  assign full = rdata_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else if (accept) begin
      rdata       <= shift;
      rdata_valid <= 1'b1;
    end else if (pop) begin
      rdata_valid <= 1'b0;
    end
  end
`endif

endmodule
